// File: rtl/input_handshake_unit_pkg.sv
// processor_pkg: shared constants and INPUT-handshake state encoding
//   OPCODE_INPUT   : opcode of the INPUT instruction
//   DEFAULT_DATA_W : default width of the board data switch word
//   in_state_e     : handshake FSM states
package processor_pkg;
  localparam logic [3:0] OPCODE_INPUT = 4'b1101;
  localparam int DEFAULT_DATA_W = 16;
  typedef enum logic [2:0] {
    IN_IDLE         = 3'd0,
    IN_ARM          = 3'd1,
    IN_WAIT_PRESS   = 3'd2,
    IN_WAIT_RELEASE = 3'd3,
    IN_DONE         = 3'd4
  } in_state_e;
endpackage

// File: rtl/input_handshake_unit_switch_debouncer.sv
// switch_debouncer: two-flop synchronizer, stability counter and edge pulses
//   clk          : clock
//   reset        : synchronous active-low reset
//   i_switch_raw : asynchronous switch input
//   o_sw_level   : debounced level
//   o_press      : one-cycle pulse on debounced 0->1
//   o_release    : one-cycle pulse on debounced 1->0
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_switch_raw,
  output logic o_sw_level,
  output logic o_press,
  output logic o_release
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic             r_sync1, r_sync2, r_level, r_level_d;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_switch_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // any return to the current level restarts the stability window
      if (r_sync2 == r_level) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign o_sw_level = r_level;
  assign o_press    = r_level & ~r_level_d;
  assign o_release  = ~r_level & r_level_d;
endmodule

// File: rtl/input_handshake_unit.sv
// input_handshake_unit: stalls the PC on INPUT until a confirm switch press/release, then hands over the captured word
//   clk        : processor clock
//   reset      : synchronous active-low reset
//   input_req  : current instruction is INPUT
//   switch_raw : asynchronous confirm switch
//   data_raw   : board data switches
//   stall      : hold PC
//   data_valid : one-cycle pulse, data_out is committed this cycle
//   data_out   : captured word, held until next capture
//   sw_level   : debounced switch level
//   timeout    : pulses with data_valid when the wait expired (only with INPUT_TIMEOUT_EN)
// Optional feature macro: INPUT_TIMEOUT_EN adds TIMEOUT_CYCLES and the timeout output.
module input_handshake_unit
  import processor_pkg::*;
#(
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
`ifdef INPUT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_req,
  input  logic              switch_raw,
  input  logic [DATA_W-1:0] data_raw,
  output logic              stall,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              sw_level
`ifdef INPUT_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);
  in_state_e         r_state, w_next;
  logic              w_press, w_release, w_busy;
  logic [DATA_W-1:0] r_data;
  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_deb (
    .clk(clk),
    .reset(reset),
    .i_switch_raw(switch_raw),
    .o_sw_level(sw_level),
    .o_press(w_press),
    .o_release(w_release)
  );
  assign w_busy = (r_state == IN_ARM) || (r_state == IN_WAIT_PRESS) || (r_state == IN_WAIT_RELEASE);
`ifdef INPUT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timed_out, w_to_hit;
  assign w_to_hit = w_busy && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_to_cnt    <= w_busy && !w_to_hit ? r_to_cnt + TO_W'(1) : '0;
      r_timed_out <= w_to_hit;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IN_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      // a switch already held at request time must be released first
      IN_IDLE:         w_next = input_req ? (sw_level ? IN_ARM : IN_WAIT_PRESS) : IN_IDLE;
      IN_ARM:          w_next = w_release ? IN_WAIT_PRESS : IN_ARM;
      IN_WAIT_PRESS:   w_next = w_press ? IN_WAIT_RELEASE : IN_WAIT_PRESS;
      IN_WAIT_RELEASE: w_next = w_release ? IN_DONE : IN_WAIT_RELEASE;
      default:         w_next = IN_IDLE;
    endcase
`ifdef INPUT_TIMEOUT_EN
    if (w_to_hit) w_next = IN_DONE;
`endif
  end
  always_comb begin
    stall      = reset && ((r_state == IN_IDLE && input_req) || w_busy);
    data_valid = reset && (r_state == IN_DONE);
`ifdef INPUT_TIMEOUT_EN
    timeout    = data_valid && r_timed_out;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) r_data <= '0;
`ifdef INPUT_TIMEOUT_EN
    // an expired wait before capture hands over zero instead of a stale word
    else if (w_to_hit && r_state != IN_WAIT_RELEASE) r_data <= '0;
`endif
    else if (r_state == IN_WAIT_PRESS && w_press) r_data <= data_raw;
  end
  assign data_out = r_data;
endmodule

// File: tb/tb_input_handshake_unit.sv
// tb_input_handshake_unit: directed self-checking bench for input_handshake_unit (DEBOUNCE_CYCLES=4)
module tb_input_handshake_unit;
  logic        clk = 1'b0;
  logic        reset, input_req, switch_raw;
  logic [15:0] data_raw, data_out;
  logic        stall, data_valid, sw_level;
`ifdef INPUT_TIMEOUT_EN
  logic        timeout;
`endif
  int n_chk = 0, n_pass = 0, n_valid = 0;
  input_handshake_unit dut (
    .clk(clk),
    .reset(reset),
    .input_req(input_req),
    .switch_raw(switch_raw),
    .data_raw(data_raw),
    .stall(stall),
    .data_valid(data_valid),
    .data_out(data_out),
    .sw_level(sw_level)
`ifdef INPUT_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (data_valid === 1'b1) n_valid <= n_valid + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // press at the current negedge, release hold cycles later; ends in the DONE cycle
  task automatic press_release(input int hold, input string tag);
    switch_raw = 1'b1;
    cyc(hold);
    switch_raw = 1'b0;
    cyc(6);
    chk({tag, "_pre_stall"}, stall, 1);
    chk({tag, "_pre_dv"}, data_valid, 0);
    cyc(1);
    chk({tag, "_dv"}, data_valid, 1);
    chk({tag, "_dv_stall"}, stall, 0);
  endtask
  initial begin
    reset = 1'b0; input_req = 1'b1; switch_raw = 1'b1; data_raw = 16'h00A5;
    cyc(3);
    chk("rst_stall", stall, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_level", sw_level, 0);
    reset = 1'b1;
    #1;
    chk("rel_stall", stall, 1);
    cyc(5);
    chk("rel_level5", sw_level, 0);
    cyc(1);
    chk("rel_level6", sw_level, 1);
    chk("rel_stall6", stall, 1);
    reset = 1'b0; switch_raw = 1'b0; input_req = 1'b0;
    cyc(3);
    chk("abort_dout", data_out, 0);
    chk("abort_stall", stall, 0);
    chk("abort_nvalid", n_valid, 0);
    reset = 1'b1;
    cyc(1);
    input_req = 1'b1; data_raw = 16'h00A5;
    cyc(2);
    switch_raw = 1'b1;
    cyc(6);
    chk("cap_level", sw_level, 1);
    chk("cap_dout_pre", data_out, 0);
    cyc(1);
    chk("cap_dout", data_out, 16'h00A5);
    chk("cap_stall", stall, 1);
    data_raw = 16'hFFFF;
    cyc(13);
    switch_raw = 1'b0;
    cyc(6);
    chk("cap_level_low", sw_level, 0);
    chk("cap_stall_rel", stall, 1);
    chk("cap_dv_pre", data_valid, 0);
    cyc(1);
    chk("cap_dv", data_valid, 1);
    chk("cap_dv_stall", stall, 0);
    input_req = 1'b0;
    cyc(1);
    chk("cap_idle_dv", data_valid, 0);
    chk("cap_hold", data_out, 16'h00A5);
    chk("cap_nvalid", n_valid, 1);
    input_req = 1'b1; data_raw = 16'h5A5A;
    cyc(2);
    switch_raw = 1'b1;
    cyc(3);
    switch_raw = 1'b0;
    cyc(8);
    chk("gl_level", sw_level, 0);
    chk("gl_stall", stall, 1);
    chk("gl_dout", data_out, 16'h00A5);
    chk("gl_nvalid", n_valid, 1);
    press_release(10, "gl_pr");
    input_req = 1'b0;
    cyc(1);
    chk("gl_dout_after", data_out, 16'h5A5A);
    chk("gl_nvalid2", n_valid, 2);
    switch_raw = 1'b1; data_raw = 16'h0000;
    cyc(8);
    chk("held_level", sw_level, 1);
    input_req = 1'b1;
    cyc(1);
    chk("held_stall", stall, 1);
    data_raw = 16'h1234;
    cyc(3);
    switch_raw = 1'b0;
    cyc(8);
    chk("held_rel_level", sw_level, 0);
    chk("held_rel_stall", stall, 1);
    chk("held_rel_dout", data_out, 16'h5A5A);
    chk("held_rel_nvalid", n_valid, 2);
    data_raw = 16'h0F0F;
    press_release(10, "held_pr");
    input_req = 1'b0;
    cyc(1);
    chk("held_dout", data_out, 16'h0F0F);
    chk("held_nvalid", n_valid, 3);
    input_req = 1'b1; data_raw = 16'h1111;
    cyc(2);
    press_release(8, "b2b1");
    cyc(1);
    chk("b2b_idle_stall", stall, 1);
    chk("b2b_idle_dout", data_out, 16'h1111);
    cyc(10);
    chk("b2b_wait_stall", stall, 1);
    chk("b2b_wait_nvalid", n_valid, 4);
    data_raw = 16'h2222;
    press_release(8, "b2b2");
    input_req = 1'b0;
    cyc(1);
    chk("b2b_dout", data_out, 16'h2222);
    chk("b2b_nvalid", n_valid, 5);
    chk("b2b_stall_end", stall, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
